// File: rtl/viterbi_ber_checker_if.sv
// Bus bundle for the Viterbi BER checker: tx/rx bit streams in, lock status and counters out.
// With BER_CHECKER_FIRST_ERR_EN defined it also carries the first-error index/valid pair.
interface viterbi_ber_checker_if #(
    parameter int MAX_LAG = 63,
    parameter int CNT_W   = 32
);
    localparam int LAG_W = $clog2(MAX_LAG + 1);

    // Both streams are valid-only: a bit is taken on every clock where its valid is high,
    // there is no ready/backpressure, and tx/rx valids may be high in the same cycle.
    logic             tx_valid_i;
    logic             tx_bit_i;
    logic             rx_valid_i;
    logic             rx_bit_i;
    logic             clear_i;
    logic             locked_o;
    logic [LAG_W-1:0] lag_o;
    logic [CNT_W-1:0] bit_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             err_pulse_o;
    logic             state_o;      // FSM state for debug: 0 = SEARCH, 1 = LOCKED
`ifdef BER_CHECKER_FIRST_ERR_EN
    logic [CNT_W-1:0] first_err_idx_o;
    logic             first_err_vld_o;
`endif

    modport master (
        output tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i, clear_i,
        input  locked_o, lag_o, bit_cnt_o, err_cnt_o, err_pulse_o, state_o
`ifdef BER_CHECKER_FIRST_ERR_EN
        , input first_err_idx_o, first_err_vld_o
`endif
    );

    modport slave (
        input  tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i, clear_i,
        output locked_o, lag_o, bit_cnt_o, err_cnt_o, err_pulse_o, state_o
`ifdef BER_CHECKER_FIRST_ERR_EN
        , output first_err_idx_o, first_err_vld_o
`endif
    );
endinterface

// File: rtl/viterbi_ber_checker.sv
// Loopback BER checker: searches the encoder-to-decoder lag, locks, then counts bits and errors.
// Optional first-error capture is enabled with the BER_CHECKER_FIRST_ERR_EN macro.
module viterbi_ber_checker #(
    parameter int MAX_LAG     = 63,
    parameter int LOCK_LEN    = 32,
    parameter int WIN         = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    viterbi_ber_checker_if.slave bus
);
    localparam int LAG_W  = $clog2(MAX_LAG + 1);
    localparam int FILL_W = $clog2(MAX_LAG + 2);
    localparam int MCNT_W = $clog2(LOCK_LEN + 1);
    localparam int WCNT_W = $clog2(WIN + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [MAX_LAG:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [LAG_W-1:0]    lag_q, lag_d, lag_inc;
    logic [MCNT_W-1:0]   match_q, match_d;
    logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WCNT_W-1:0]   win_err_q, win_err_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                err_pulse_q, err_pulse_d;
    logic                cmp, mis;
`ifdef BER_CHECKER_FIRST_ERR_EN
    logic [CNT_W-1:0]    first_idx_q, first_idx_d;
    logic                first_vld_q, first_vld_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        lag_d       = lag_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
`ifdef BER_CHECKER_FIRST_ERR_EN
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
`endif
        // Compare uses the history as it stood before this cycle's shift.
        cmp     = bus.rx_valid_i && (fill_q > FILL_W'(lag_q));
        mis     = bus.rx_bit_i != hist_q[lag_q];
        lag_inc = (lag_q == LAG_W'(MAX_LAG)) ? '0 : lag_q + 1'b1;

        if (bus.tx_valid_i) begin
            hist_d = {hist_q[MAX_LAG-1:0], bus.tx_bit_i};
            if (fill_q != FILL_W'(MAX_LAG + 1)) fill_d = fill_q + 1'b1;
        end

        if (cmp) begin
            case (state_q)
                SEARCH: begin
                    if (mis) begin
                        match_d = '0;
                        lag_d   = lag_inc;
                    end else if (match_q == MCNT_W'(LOCK_LEN - 1)) begin
                        state_d   = LOCKED;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    bit_cnt_d = sat_inc(bit_cnt_q);
                    if (mis) begin
                        err_cnt_d   = sat_inc(err_cnt_q);
                        win_err_d   = win_err_q + 1'b1;
                        err_pulse_d = 1'b1;
`ifdef BER_CHECKER_FIRST_ERR_EN
                        if (!first_vld_q) begin
                            first_idx_d = bit_cnt_q;
                            first_vld_d = 1'b1;
                        end
`endif
                    end
                    // Window closes on its WIN-th compare, counting this compare's error.
                    if (win_cnt_q == WCNT_W'(WIN - 1)) begin
                        if (win_err_d >= WCNT_W'(UNLOCK_ERRS)) begin
                            state_d = SEARCH;
                            lag_d   = lag_inc;
                            match_d = '0;
                        end
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (bus.clear_i) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
`ifdef BER_CHECKER_FIRST_ERR_EN
            first_idx_d = '0;
            first_vld_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            lag_q       <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
`ifdef BER_CHECKER_FIRST_ERR_EN
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            lag_q       <= lag_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
`ifdef BER_CHECKER_FIRST_ERR_EN
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
`endif
        end
    end

    assign bus.locked_o    = (state_q == LOCKED);
    assign bus.state_o     = state_q;
    assign bus.lag_o       = lag_q;
    assign bus.bit_cnt_o   = bit_cnt_q;
    assign bus.err_cnt_o   = err_cnt_q;
    assign bus.err_pulse_o = err_pulse_q;
`ifdef BER_CHECKER_FIRST_ERR_EN
    assign bus.first_err_idx_o = first_idx_q;
    assign bus.first_err_vld_o = first_vld_q;
`endif
endmodule
